// File: rtl/snake_stream_pkg.sv
// Shared types and default geometry for the snake segment streamer.
package snake_stream_pkg;

  typedef enum logic [1:0] {
    DirUp    = 2'd0,
    DirDown  = 2'd1,
    DirLeft  = 2'd2,
    DirRight = 2'd3
  } dir_e;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
  } tile_t;

  typedef enum logic [1:0] {
    StIdle,
    StUpdate,
    StStream
  } state_e;

  localparam int unsigned MaxLen   = 32;
  localparam int unsigned StartLen = 3;
  localparam int unsigned StartX   = 4;
  localparam int unsigned StartY   = 7;
  localparam int unsigned LenW     = 6;

  // Up/down and left/right differ only in bit 0.
  function automatic dir_e dir_opposite(dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/snake_stream_dir_step.sv
// Moves a tile one step in a direction, wrapping at the field edges.
module snake_stream_dir_step
  import snake_stream_pkg::*;
(
  input  tile_t tile_i,
  input  dir_e  dir_i,
  output tile_t tile_o
);

  always_comb begin
    tile_o = tile_i;
    unique case (dir_i)
      DirUp:    tile_o.y = tile_i.y - 4'd1;
      DirDown:  tile_o.y = tile_i.y + 4'd1;
      DirLeft:  tile_o.x = tile_i.x - 5'd1;
      DirRight: tile_o.x = tile_i.x + 5'd1;
      default:  tile_o = tile_i;
    endcase
  end

endmodule

// File: rtl/snake_stream.sv
// Snake body store (head tile + tail-ward direction chain) that streams every
// segment position once per pass and applies accepted moves between passes.
module snake_stream
  import snake_stream_pkg::*;
#(
  parameter int unsigned MAX_LEN   = MaxLen,
  parameter int unsigned START_LEN = StartLen,
  parameter int unsigned START_X   = StartX,
  parameter int unsigned START_Y   = StartY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_rst_n,
  input  logic       move_req,
  input  logic [1:0] move_dir,
  input  logic       move_grow,
  output logic       move_ack,
  output logic [4:0] snake_head_x,
  output logic [3:0] snake_head_y,
  output logic [4:0] snake_x,
  output logic [3:0] snake_y,
  output logic [1:0] snake_dir,
  output logic       snake_first,
  output logic       snake_last,
  output logic       snake_valid,
  output logic [5:0] snake_len,
  output logic       full,
  output logic       self_hit
);

  state_e                 state_q, state_d;
  tile_t                  head_q, head_d;
  tile_t                  pos_q, pos_d;
  logic [2*MAX_LEN-1:0]   dir_q, dir_d;
  logic [LenW-1:0]        len_q, len_d;
  logic [LenW-1:0]        k_q, k_d;
  logic                   pass_hit_q, pass_hit_d;
  logic                   self_hit_q, self_hit_d;

  tile_t                  out_tile_q, out_tile_d;
  dir_e                   out_dir_q, out_dir_d;
  logic                   out_first_q, out_first_d;
  logic                   out_last_q, out_last_d;
  logic                   out_valid_q, out_valid_d;

  tile_t                  head_step;
  tile_t                  walk_cur;
  tile_t                  walk_next;
  dir_e                   cur_dir;
  logic                   cur_hit;
  logic                   len_full;

  assign len_full = (len_q == LenW'(MAX_LEN));

  // Beat 0 is the head itself; later beats come from the walking register.
  assign walk_cur = (k_q == '0) ? head_q : pos_q;
  assign cur_hit  = (k_q != '0) && (walk_cur == head_q);

  always_comb begin
    cur_dir = DirLeft;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (k_q == LenW'(i)) cur_dir = dir_e'(dir_q[2*i +: 2]);
    end
  end

  snake_stream_dir_step u_head_step (
    .tile_i (head_q),
    .dir_i  (dir_e'(move_dir)),
    .tile_o (head_step)
  );

  snake_stream_dir_step u_walk_step (
    .tile_i (walk_cur),
    .dir_i  (cur_dir),
    .tile_o (walk_next)
  );

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    len_d       = len_q;
    k_d         = k_q;
    pass_hit_d  = pass_hit_q;
    self_hit_d  = self_hit_q;
    out_tile_d  = out_tile_q;
    out_dir_d   = out_dir_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        k_d        = '0;
        pass_hit_d = 1'b0;
        state_d    = move_req ? StUpdate : StStream;
      end
      StUpdate: begin
        head_d = head_step;
        dir_d  = {dir_q[2*MAX_LEN-3:0], 2'(dir_opposite(dir_e'(move_dir)))};
        if (move_grow && !len_full) len_d = len_q + LenW'(1);
        state_d = StStream;
      end
      StStream: begin
        out_valid_d = 1'b1;
        out_tile_d  = walk_cur;
        out_dir_d   = cur_dir;
        out_first_d = (k_q == '0);
        out_last_d  = (k_q == len_q - LenW'(1));
        pos_d       = walk_next;
        pass_hit_d  = pass_hit_q | cur_hit;
        if (k_q == len_q - LenW'(1)) begin
          self_hit_d = self_hit_q | pass_hit_q | cur_hit;
          state_d    = StIdle;
        end else begin
          k_d = k_q + LenW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !game_rst_n) begin
      state_q     <= StIdle;
      head_q      <= '{x: 5'(START_X), y: 4'(START_Y)};
      pos_q       <= '0;
      dir_q       <= {MAX_LEN{2'(DirLeft)}};
      len_q       <= LenW'(START_LEN);
      k_q         <= '0;
      pass_hit_q  <= 1'b0;
      self_hit_q  <= 1'b0;
      out_tile_q  <= '0;
      out_dir_q   <= DirLeft;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      len_q       <= len_d;
      k_q         <= k_d;
      pass_hit_q  <= pass_hit_d;
      self_hit_q  <= self_hit_d;
      out_tile_q  <= out_tile_d;
      out_dir_q   <= out_dir_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Acknowledge is suppressed while either reset is held so reset always wins.
  assign move_ack     = (state_q == StUpdate) && rst_n && game_rst_n;
  assign snake_head_x = head_q.x;
  assign snake_head_y = head_q.y;
  assign snake_x      = out_tile_q.x;
  assign snake_y      = out_tile_q.y;
  assign snake_dir    = 2'(out_dir_q);
  assign snake_first  = out_first_q;
  assign snake_last   = out_last_q;
  assign snake_valid  = out_valid_q;
  assign snake_len    = len_q;
  assign full         = len_full;
  assign self_hit     = self_hit_q;

endmodule

// File: doc/snake_stream.md
SNAKE_STREAM -- requirements
Module: snake_stream

Interface
REQ-001 Parameter MAX_LEN, 32, maximum number of segments including the head.
REQ-002 Parameter START_LEN, 3, body length after reset.
REQ-003 Parameter START_X, 4, head tile x after reset.
REQ-004 Parameter START_Y, 7, head tile y after reset.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 game_rst_n  input  1  game restart, synchronous, active-low; same effect as rst_n.
REQ-008 move_req  input  1  request to advance the snake one tile; held until move_ack.
REQ-009 move_dir  input  2  head travel direction: 0 up, 1 down, 2 left, 3 right.
REQ-010 move_grow  input  1  append one segment with this move (apple eaten).
REQ-011 move_ack  output  1  one-cycle pulse; move_dir and move_grow are sampled in this cycle.
REQ-012 snake_head_x / snake_head_y  output  5 / 4  current head tile.
REQ-013 snake_x / snake_y  output  5 / 4  streamed segment tile.
REQ-014 snake_dir  output  2  direction from the streamed segment toward its tail-ward neighbour.
REQ-015 snake_first / snake_last / snake_valid  output  1 each  head segment / tail segment / stream beat valid.
REQ-016 snake_len  output  6  current length.
REQ-017 full  output  1  snake_len == MAX_LEN.
REQ-018 self_hit  output  1  sticky: the head overlapped a body segment.

Function
REQ-019 State storage is the head tile plus dir[0..MAX_LEN-1]; dir[i] is the tail-ward direction of segment i.
REQ-020 Opposite direction is dir with bit 0 inverted; step: up y-1, down y+1, left x-1, right x+1, modulo field width (5/4 bits).
REQ-021 FSM states are IDLE, UPDATE and STREAM; reset state is IDLE.
REQ-022 IDLE: if move_req then go to UPDATE, else go to STREAM.
REQ-023 UPDATE lasts exactly one cycle and asserts move_ack; next state is STREAM.
REQ-024 In the UPDATE commit: head <= step(head, move_dir); dir[0] <= opposite(move_dir); dir[i+1] <= dir[i].
REQ-025 In the UPDATE commit: snake_len increments when move_grow and not full; otherwise length is unchanged and the tail is dropped.
REQ-026 move_req is accepted only from IDLE; a request raised mid-pass waits at most snake_len+1 cycles.
REQ-027 STREAM: beat k (k = 0..snake_len-1) is presented in the k-th cycle of the pass; outputs are registered, so each beat is visible one cycle after its FSM cycle.
REQ-028 Beat 0 is the head with snake_first=1; beat k+1 position = step(beat k position, dir[k]).
REQ-029 snake_last=1 only on beat snake_len-1; after that beat the FSM returns to IDLE.
REQ-030 snake_valid=0 outside beats; snake_x/y/dir/first/last are then don't-care but held stable.
REQ-031 Pass-hit flag: cleared at pass start; set when a beat k>=1 position equals the head.
REQ-032 At pass end, self_hit <= self_hit | pass-hit.
REQ-033 A reversal move (move_dir == dir[0]) is accepted; self_hit sets at the end of the following pass.
REQ-034 move_grow when full: length stays MAX_LEN and full remains 1.

Reset
REQ-035 While rst_n or game_rst_n is low at a clock edge: head=(START_X,START_Y), snake_len=START_LEN, all dir=left, FSM IDLE, pass-hit=0.
REQ-036 Output values during reset: move_ack=0, snake_valid=0, self_hit=0, full=(START_LEN==MAX_LEN).
REQ-037 Reset during a pass aborts the pass immediately; the next cycle is IDLE.
REQ-038 Reset coincident with move_req: reset wins; no move_ack is issued.

Structure
REQ-039 Direction encoding typedef, MAX_LEN, START_* constants reside in the shared common package.
REQ-040 One combinational sub-module dir_step (tile in, direction in, tile out) is instantiated for head update and stream walking.
REQ-041 dir storage is a flat shift register; no RAM macro.

Verification
REQ-042 Reset, no moves -> passes of 3 beats every 4 cycles: beats (4,7,L,first), (3,7,L), (2,7,L,last); self_hit=0.
REQ-043 move_req with move_dir=down during a pass -> move_ack within 4 cycles; next pass gives head (4,8), dir[0]=up, len 3.
REQ-044 Five moves, all with move_grow=1 -> snake_len=8; last pass has 8 beats, and snake_last appears only on beat 7.
REQ-045 Move right then move left (reversal) -> self_hit=1 after the next complete pass and stays 1 until game_rst_n.
REQ-046 Grow to MAX_LEN and then one more grow move -> full=1, snake_len=32, and the tail advances.
REQ-047 game_rst_n pulse mid-pass -> snake_valid=0 in the next cycle; state returns to the REQ-042 values.
